// File: rtl/music_player_ctrl_if.sv
// Score ROM link: the controller presents a beat index, the ROM answers with two tones.
// Optional build macro used by the controller: MUSIC_PLAYER_MONO_EN.
interface music_player_ctrl_if;
    // No valid/ready: toneL/toneR are combinational ROM data for the current
    // ibeatNum and are taken as valid every cycle; a change is the only event.
    logic [11:0] ibeatNum;
    logic [31:0] toneL;
    logic [31:0] toneR;

    modport master (output ibeatNum, input toneL, input toneR);
    modport slave  (input ibeatNum, output toneL, output toneR);
endinterface

// File: rtl/music_player_ctrl.sv
// Beat sequencer, per-channel tone-to-half-period divider and square wave, I2S serialiser.
// Define MUSIC_PLAYER_MONO_EN to drop the right channel and send the left sample on both halves.
module music_tone_chan #(
    parameter int          CLK_HZ    = 100_000_000,
    parameter logic [15:0] AMPLITUDE = 16'h2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] tone,
    output logic [15:0] sample,
    output logic [1:0]  dbg_state,
    output logic [31:0] dbg_half
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] tone_q, tone_d;
    logic [31:0] half_q, half_d;
    logic [31:0] quo_q, quo_d;
    logic [32:0] rem_q, rem_d;
    logic [32:0] rem_sh;
    logic [4:0]  step_q, step_d;
    logic [31:0] wcnt_q, wcnt_d;
    logic        phase_q, phase_d;
    logic        half_wr;
    logic        muted;

    assign muted  = (half_q < 32'd2) || !en;
    // quo_q doubles as the dividend shift register; quotient bits enter from the right
    assign rem_sh = {rem_q[31:0], quo_q[31]};

    always_comb begin
        state_d = state_q;
        tone_d  = tone_q;
        half_d  = half_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        step_d  = step_q;
        half_wr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tone != tone_q) begin
                    tone_d = tone;
                    if (tone == 32'd0) begin
                        half_d  = 32'd0;
                        half_wr = 1'b1;
                    end else begin
                        rem_d   = 33'd0;
                        quo_d   = 32'(CLK_HZ);
                        step_d  = 5'd0;
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                if (rem_sh >= {1'b0, tone_q}) begin
                    rem_d = rem_sh - {1'b0, tone_q};
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    quo_d = {quo_q[30:0], 1'b0};
                end
                step_d = step_q + 5'd1;
                if (step_q == 5'd31) state_d = S_DONE;
            end
            S_DONE: begin
                half_d  = {1'b0, quo_q[31:1]};
                half_wr = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        wcnt_d  = wcnt_q + 32'd1;
        phase_d = phase_q;
        if (muted || half_wr) begin
            wcnt_d  = 32'd0;
            phase_d = 1'b0;
        end else if (wcnt_q == half_q - 32'd1) begin
            wcnt_d  = 32'd0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tone_q  <= 32'd0;
            half_q  <= 32'd0;
            quo_q   <= 32'd0;
            rem_q   <= 33'd0;
            step_q  <= 5'd0;
            wcnt_q  <= 32'd0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tone_q  <= tone_d;
            half_q  <= half_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            step_q  <= step_d;
            wcnt_q  <= wcnt_d;
            phase_q <= phase_d;
        end
    end

    assign sample    = muted ? 16'd0 : (phase_q ? AMPLITUDE : (~AMPLITUDE + 16'd1));
    assign dbg_state = state_q;
    assign dbg_half  = half_q;
endmodule

module music_player_ctrl #(
    parameter int          CLK_HZ        = 100_000_000,
    parameter int          BEATS_PER_SEC = 8,
    parameter int          BEAT_LEN      = 64,
    parameter logic [15:0] AMPLITUDE     = 16'h2000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                restart,
    music_player_ctrl_if.master rom,
    output logic                audio_mclk,
    output logic                audio_sck,
    output logic                audio_lrck,
    output logic                audio_sdin,
    output logic [1:0]          dbg_state_l,
    output logic [1:0]          dbg_state_r,
    output logic [31:0]         dbg_half_l,
    output logic [31:0]         dbg_half_r
);
    localparam logic [31:0] PRESC_MAX = 32'(CLK_HZ / BEATS_PER_SEC - 1);

    logic [31:0] presc_q, presc_d;
    logic [11:0] beat_q, beat_d;
    logic [8:0]  c_q, c_d;
    logic [15:0] frame_l_q, frame_l_d;
    logic [15:0] frame_r_q, frame_r_d;
    logic        sdin_q, sdin_d;
    logic [15:0] sample_l, sample_r;
    logic [15:0] sdin_word;

    always_comb begin
        presc_d = presc_q;
        beat_d  = beat_q;
        if (restart) begin
            presc_d = 32'd0;
            beat_d  = 12'd0;
        end else if (en) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = 32'd0;
                beat_d  = (beat_q == 12'(BEAT_LEN - 1)) ? 12'd0 : beat_q + 12'd1;
            end else begin
                presc_d = presc_q + 32'd1;
            end
        end
    end

    music_tone_chan #(.CLK_HZ(CLK_HZ), .AMPLITUDE(AMPLITUDE)) u_chan_l (
        .clk(clk), .rst(rst), .en(en), .tone(rom.toneL),
        .sample(sample_l), .dbg_state(dbg_state_l), .dbg_half(dbg_half_l)
    );

`ifdef MUSIC_PLAYER_MONO_EN
    logic unused_tone_r;
    assign unused_tone_r = ^rom.toneR;
    assign sample_r      = sample_l;
    assign dbg_state_r   = 2'd0;
    assign dbg_half_r    = 32'd0;
`else
    music_tone_chan #(.CLK_HZ(CLK_HZ), .AMPLITUDE(AMPLITUDE)) u_chan_r (
        .clk(clk), .rst(rst), .en(en), .tone(rom.toneR),
        .sample(sample_r), .dbg_state(dbg_state_r), .dbg_half(dbg_half_r)
    );
`endif

    // sdin is registered from the current count, so it lags the sck falling edge by one clk
    assign sdin_word = c_q[8] ? frame_r_q : frame_l_q;

    always_comb begin
        c_d       = c_q + 9'd1;
        frame_l_d = frame_l_q;
        frame_r_d = frame_r_q;
        sdin_d    = sdin_word[4'd15 - c_q[7:4]];
        if (c_q == 9'd511) begin
            frame_l_d = sample_l;
            frame_r_d = sample_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= 32'd0;
            beat_q    <= 12'd0;
            c_q       <= 9'd0;
            frame_l_q <= 16'd0;
            frame_r_q <= 16'd0;
            sdin_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            beat_q    <= beat_d;
            c_q       <= c_d;
            frame_l_q <= frame_l_d;
            frame_r_q <= frame_r_d;
            sdin_q    <= sdin_d;
        end
    end

    assign rom.ibeatNum = beat_q;
    assign audio_mclk   = c_q[1];
    assign audio_sck    = c_q[3];
    assign audio_lrck   = c_q[8];
    assign audio_sdin   = sdin_q;
endmodule

// File: tb/tb_music_player_ctrl.sv
// Self-checking bench for music_player_ctrl: per-cycle reference model, serial decoder, directed and random phases.
// Honours MUSIC_PLAYER_MONO_EN the same way as the design.
module tb_music_player_ctrl;
    localparam int          CLK_HZ   = 1000;
    localparam int          BPS      = 10;
    localparam int          BEAT_LEN = 4;
    localparam int          PRESC    = CLK_HZ / BPS;
    localparam logic [15:0] AMP      = 16'h2000;
    localparam logic [15:0] AMP_NEG  = 16'hE000;
    localparam int          W        = 80;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic restart = 1'b0;
    logic audio_mclk, audio_sck, audio_lrck, audio_sdin;
    logic [1:0]  dbg_state_l, dbg_state_r;
    logic [31:0] dbg_half_l, dbg_half_r;

    always #5 clk = ~clk;

    music_player_ctrl_if rom_if ();

    music_player_ctrl #(
        .CLK_HZ(CLK_HZ), .BEATS_PER_SEC(BPS), .BEAT_LEN(BEAT_LEN), .AMPLITUDE(AMP)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .restart(restart), .rom(rom_if),
        .audio_mclk(audio_mclk), .audio_sck(audio_sck), .audio_lrck(audio_lrck),
        .audio_sdin(audio_sdin), .dbg_state_l(dbg_state_l), .dbg_state_r(dbg_state_r),
        .dbg_half_l(dbg_half_l), .dbg_half_r(dbg_half_r)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned m_play = 0;
    int unsigned m_e = 0;
    logic [8:0]  m_c = 9'd0;
    logic [15:0] m_fl = 16'd0, m_fr = 16'd0;
    logic        m_sdin = 1'b0;
    int unsigned m_lat[2], m_half[2], m_pend[2], m_done[2], m_start[2];
    bit          m_busy[2];
    logic [W-1:0] exp_q[$];

    function automatic logic [15:0] m_sample(input int ch, input bit en_v);
        if (m_half[ch] < 2 || !en_v) return 16'h0000;
        return (((m_e - m_start[ch]) / m_half[ch]) % 2 == 1) ? AMP : AMP_NEG;
    endfunction

    // One clock edge of a channel: tone-change detect, 34-cycle division latency, wave restart.
    task automatic m_chan(input int ch, input logic [31:0] tone, input bit en_v);
        bit muted_pre, wr;
        int unsigned nh;
        muted_pre = (m_half[ch] < 2) || !en_v;
        wr = 1'b0;
        nh = m_half[ch];
        if (!m_busy[ch]) begin
            if (tone != m_lat[ch]) begin
                m_lat[ch] = tone;
                if (tone == 0) begin
                    nh = 0;
                    wr = 1'b1;
                end else begin
                    m_busy[ch] = 1'b1;
                    m_done[ch] = m_e + 33;
                    m_pend[ch] = (CLK_HZ / tone) >> 1;
                end
            end
        end else if (m_e == m_done[ch]) begin
            nh = m_pend[ch];
            wr = 1'b1;
            m_busy[ch] = 1'b0;
        end
        if (muted_pre || wr) m_start[ch] = m_e;
        m_half[ch] = nh;
    endtask

    always @(posedge clk or posedge rst) begin
        logic [15:0] sl, sr, word;
        int idx;
        logic [11:0] beat;
        if (rst) begin
            m_play = 0; m_e = 0; m_c = 9'd0; m_fl = 16'd0; m_fr = 16'd0; m_sdin = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                m_lat[ch] = 0; m_half[ch] = 0; m_pend[ch] = 0; m_done[ch] = 0;
                m_start[ch] = 0; m_busy[ch] = 1'b0;
            end
            exp_q.delete();
        end else begin
            sl = m_sample(0, en);
`ifdef MUSIC_PLAYER_MONO_EN
            sr = sl;
`else
            sr = m_sample(1, en);
`endif
            word = m_c[8] ? m_fr : m_fl;
            idx = 15 - int'(m_c[7:4]);
            m_sdin = word[idx];
            if (m_c == 9'd511) begin
                m_fl = sl;
                m_fr = sr;
            end
            m_c = m_c + 9'd1;
            if (restart) m_play = 0;
            else if (en) m_play++;
            m_e++;
            m_chan(0, rom_if.toneL, en);
`ifndef MUSIC_PLAYER_MONO_EN
            m_chan(1, rom_if.toneR, en);
`endif
            beat = 12'((m_play / PRESC) % BEAT_LEN);
            exp_q.push_back({beat, m_c[1], m_c[3], m_c[8], m_sdin, m_half[0], m_half[1]});
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ibeatNum", 64'(rom_if.ibeatNum), 64'(e[79:68]));
            check("audio_mclk", 64'(audio_mclk), 64'(e[67]));
            check("audio_sck", 64'(audio_sck), 64'(e[66]));
            check("audio_lrck", 64'(audio_lrck), 64'(e[65]));
            check("audio_sdin", 64'(audio_sdin), 64'(e[64]));
            check("half_l", 64'(dbg_half_l), 64'(e[63:32]));
            check("half_r", 64'(dbg_half_r), 64'(e[31:0]));
        end
    end

    // ---------------- serial decoder (DAC side) ----------------
    logic [15:0] dec_sh = 16'd0;
    logic [15:0] word_l = 16'd0, word_r = 16'd0;
    int          dec_n = 0;
    logic        dec_lr = 1'b0;

    always @(posedge audio_sck or posedge rst) begin
        if (rst) begin
            dec_n = 0; dec_lr = 1'b0; word_l = 16'd0; word_r = 16'd0;
        end else begin
            if (audio_lrck != dec_lr) begin
                dec_lr = audio_lrck;
                dec_n = 0;
            end
            dec_sh = {dec_sh[14:0], audio_sdin};
            dec_n++;
            if (dec_n == 16) begin
                if (!dec_lr) word_l = dec_sh;
                else begin
                    word_r = dec_sh;
`ifdef MUSIC_PLAYER_MONO_EN
                    check("mono_r_eq_l", 64'(word_r), 64'(word_l));
`endif
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_tones(input logic [31:0] l, input logic [31:0] r);
        rom_if.toneL = l;
        rom_if.toneR = r;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
    endtask

    function automatic logic [31:0] rand_tone();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd500;
            2: return 32'($urandom_range(1, 20));
            3: return 32'($urandom_range(21, 600));
            4: return $urandom;
            default: return 32'($urandom_range(900, 1100));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        set_tones(32'd0, 32'd0);
        cyc(3);
        check("rst_beat", 64'(rom_if.ibeatNum), 64'd0);
        check("rst_pins", 64'({audio_mclk, audio_sck, audio_lrck, audio_sdin}), 64'd0);
        check("rst_half", 64'(dbg_half_l), 64'd0);
        rst = 1'b0;
        cyc(2);
        check("c_from_0_mclk", 64'(audio_mclk), 64'd1);

        // beat sequencing
        en = 1'b1;
        pulse_restart();
        cyc(99);  check("beat_hold0", 64'(rom_if.ibeatNum), 64'd0);
        cyc(1);   check("beat_step1", 64'(rom_if.ibeatNum), 64'd1);
        cyc(300); check("beat_wrap", 64'(rom_if.ibeatNum), 64'd0);
        cyc(250); check("beat_2", 64'(rom_if.ibeatNum), 64'd2);
        en = 1'b0;
        cyc(250); check("pause_hold", 64'(rom_if.ibeatNum), 64'd2);
        en = 1'b1;
        cyc(49);  check("resume_presc", 64'(rom_if.ibeatNum), 64'd2);
        cyc(1);   check("resume_step", 64'(rom_if.ibeatNum), 64'd3);
        cyc(100); check("beat_wrap2", 64'(rom_if.ibeatNum), 64'd0);
        cyc(99);
        pulse_restart();
        check("restart_over_tick", 64'(rom_if.ibeatNum), 64'd0);
        cyc(100); check("after_restart", 64'(rom_if.ibeatNum), 64'd1);

        // divider latency and re-evaluation
        set_tones(32'd100, 32'd0);
        cyc(33); check("div_lat33", 64'(dbg_half_l), 64'd0);
        cyc(1);  check("div_lat34", 64'(dbg_half_l), 64'd5);
        check("model_half_100", 64'(m_half[0]), 64'd5);
        set_tones(32'd25, 32'd0);
        cyc(10);
        set_tones(32'd50, 32'd0);
        cyc(24); check("first_pass", 64'(dbg_half_l), 64'd20);
        cyc(33); check("second_pass_pre", 64'(dbg_half_l), 64'd20);
        cyc(1);  check("second_pass", 64'(dbg_half_l), 64'd10);
        cyc(1100);
        check("word_l_audible", 64'((word_l == AMP) || (word_l == AMP_NEG)), 64'd1);
`ifndef MUSIC_PLAYER_MONO_EN
        check("word_r_silent", 64'(word_r), 64'd0);
`endif

        // mute by silence code and by tone 0
        set_tones(32'd500, 32'd7);
        cyc(1134);
        check("silence_code_half", 64'(dbg_half_l), 64'd1);
        check("silence_code_word", 64'(word_l), 64'd0);
        set_tones(32'd0, 32'd7);
        cyc(1);
        check("tone0_direct", 64'(dbg_half_l), 64'd0);

        // pause mutes both channels
        set_tones(32'd100, 32'd100);
        cyc(40);
        en = 1'b0;
        cyc(1100);
        check("pause_word_l", 64'(word_l), 64'd0);
        check("pause_word_r", 64'(word_r), 64'd0);

        // asynchronous reset mid-play
        en = 1'b1;
        set_tones(32'd7, 32'd13);
        cyc(300);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_beat", 64'(rom_if.ibeatNum), 64'd0);
        check("midrst_pins", 64'({audio_mclk, audio_sck, audio_lrck, audio_sdin}), 64'd0);
        check("midrst_half", 64'(dbg_half_l), 64'd0);
        cyc(2);
        rst = 1'b0;
        cyc(8);
        check("midrst_c_sck", 64'({audio_sck, audio_mclk}), 64'b10);

        // randomized play
        for (int i = 0; i < 40; i++) begin
            en = ($urandom_range(0, 4) != 0);
            set_tones(rand_tone(), rand_tone());
            if ($urandom_range(0, 5) == 0) pulse_restart();
            cyc($urandom_range(1, 700));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/music_player_ctrl.md
# music_player_ctrl

Playback controller on the requesting side of the beat-indexed tone ROM interface. It advances the 12-bit beat index at a fixed rate and takes back the left and right tone frequencies in Hz that the ROM returns for each beat. It converts each tone into a square-wave sample stream and serialises both channels to the on-board I2S audio DAC. It sits between the score ROM and the audio Pmod pins in the top level.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz; also the dividend for tone-to-period conversion.
- BEATS_PER_SEC, 8, beat advance rate.
- BEAT_LEN, 64, number of beats in the score; index wraps from BEAT_LEN-1 to 0.
- AMPLITUDE, 16'h2000, square-wave peak magnitude (positive; the negative half is its two's complement).

- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- en, input, 1, 1 = play (beat advances, tones sounded); 0 = pause (beat holds, both channels output 0).
- restart, input, 1, single-cycle synchronous pulse; clears the beat index and the beat prescaler.
- toneL, input, 32, left tone in Hz returned by the ROM for the current ibeatNum.
- toneR, input, 32, right tone in Hz, same timing as toneL.
- ibeatNum, output, 12, registered beat index presented to the ROM.
- audio_mclk, output, 1, DAC master clock = clk/4.
- audio_sck, output, 1, DAC serial bit clock = clk/16.
- audio_lrck, output, 1, DAC word select = clk/512; 0 = left, 1 = right.
- audio_sdin, output, 1, DAC serial data, MSB first.

## Operation
- **Beat sequencer**
  - Prescaler counts 0..CLK_HZ/BEATS_PER_SEC-1 while en=1.
  - At terminal count, ibeatNum increments, wrapping BEAT_LEN-1 -> 0.
  - en=0 freezes both the prescaler and ibeatNum.
  - restart forces both to 0 in the same cycle and has priority over a simultaneous tick.
- **Tone capture, per channel**
  - The block holds a latched tone register and a 32-step restoring divider with states IDLE -> DIV (32 cycles) -> DONE (1 cycle) -> IDLE.
  - In IDLE, if the input tone differs from the latched tone, the block latches the new tone and enters DIV.
  - DONE writes half = (CLK_HZ / tone) >> 1 into the limit register.
  - A tone change during DIV is ignored until the return to IDLE, then re-evaluated.
  - Tone 0 skips division and writes half = 0 directly, in 1 cycle.
- **Mute rule**
  - A channel is muted when half < 2. This covers tone 0 and the silence code 50_000_000, which gives a quotient of 2 and therefore half = 1.
  - A channel is also muted while en=0.
  - A muted channel outputs sample 0, and its wave counter and phase are held at 0.
- **Square wave**
  - The counter runs 0..half-1.
  - At half-1 the counter wraps to 0 and the phase toggles.
  - The sample is +AMPLITUDE when phase=1 and -AMPLITUDE when phase=0.
  - When a new limit is written, the counter and phase reset to 0.
- **Serialiser**
  - A free-running 9-bit counter c drives the clocks: mclk = c[1], sck = c[3], lrck = c[8].
  - When c = 511, both channel samples latch into frame registers.
  - audio_sdin is registered from frame[lrck-selected][15 - c[7:4]]. It therefore changes 1 clk after each falling edge of sck and is stable across the rising edge of sck.

## Timing
- **Reset values:** ibeatNum=0; audio_mclk, audio_sck, audio_lrck and audio_sdin all 0; prescaler and c at 0; latched tones 0; limits 0 (both channels muted); dividers in IDLE.
- **ROM return:** ibeatNum is registered and toneL/toneR are assumed valid in the same cycle. A tone change reaches the limit register 34 cycles after ibeatNum changes (1 compare/latch + 32 DIV + 1 DONE).
- **Sample to pin:** a sample reaches the pins on the next frame boundary, at most 512 cycles later, and its MSB appears 1 cycle after c wraps to 0.
- **Reset mid-operation:** an asserted rst aborts any division and any frame immediately.
- **Pause/resume:** en 1->0->1 resumes from the held ibeatNum and the held prescaler count.

## Configuration
- **MUSIC_PLAYER_MONO_EN defined:**
  - The right-channel divider and wave generator are not built.
  - toneR is ignored.
  - The right half-frame carries the left sample.
- **MUSIC_PLAYER_MONO_EN undefined:** full stereo as described above.

## Test plan
- **Reset:** rst high mid-play -> all outputs 0 immediately. Release -> c counts from 0 and ibeatNum=0.
- **Beat sequencing:** CLK_HZ=1000, BEATS_PER_SEC=10, BEAT_LEN=4, en=1 -> ibeatNum steps every 100 cycles through 0,1,2,3,0.
  - en=0 for 250 cycles -> ibeatNum held.
  - restart together with a tick -> ibeatNum=0.
- **Divider and square wave:** CLK_HZ=1000, toneL=100 -> limit=5 after 34 cycles; the left sample toggles between +0x2000 and 0xE000 every 5 cycles.
  - Change toneL to 50 during DIV -> limit=10 after the second pass.
- **Mute:** toneL=50_000_000 (or 0) with default CLK_HZ -> left half-frames decode to 0x0000.
  - en=0 -> both half-frames decode to 0x0000.
- **Serial format:** default params, toneL=440, toneR=880 -> decoded left sign flips every ~222 frames and right every ~111 frames.
  - Bits are MSB first, and each sdin change falls exactly 1 clk after a falling edge of sck.
- **Mono build:** MUSIC_PLAYER_MONO_EN defined, toneR=880, toneL=440 -> the right half-frame equals the left half-frame in every frame.
